// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants and stage-slot record layouts for the forwarding / load-use hazard unit.
// Both slots record which register the instruction in that stage will write.
package fwd_hazard_unit_pkg;

   localparam int RA_W = 5;
   localparam logic [RA_W-1:0] ZERO_REG = '0;

   typedef logic [1:0] fwd_sel_t;

   localparam fwd_sel_t FWD_RF  = 2'd0;
   localparam fwd_sel_t FWD_WB  = 2'd1;
   localparam fwd_sel_t FWD_MEM = 2'd2;

   typedef struct packed {
      logic [RA_W-1:0] dst;
      logic            reg_write;
      logic            mem_read;
      logic            valid;
   } ex_slot_t;

   typedef struct packed {
      logic [RA_W-1:0] dst;
      logic            reg_write;
   } mem_slot_t;

   localparam ex_slot_t EX_BUBBLE = '{dst: '0, reg_write: 1'b0, mem_read: 1'b0, valid: 1'b0};
   localparam mem_slot_t MEM_EMPTY = '{dst: '0, reg_write: 1'b0};

   // A bubble carries reg_write=0, so it can never become a forwarding source in MEM.
   function automatic mem_slot_t ex_to_mem(input ex_slot_t s);
      mem_slot_t m;
      m.dst       = s.dst;
      m.reg_write = s.reg_write & s.valid;
      return m;
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_sel.sv
// Priority compare for a single EX operand: newest in-flight producer wins,
// the zero register and unused or invalid operands always read the register file.
module fwd_sel_calc
   import fwd_hazard_unit_pkg::*;
#(
   parameter int              RA_W_P     = RA_W,
   parameter logic [RA_W-1:0] ZERO_REG_P = ZERO_REG
) (
   input  logic              id_valid,
   input  logic              use_reg,
   input  logic [RA_W_P-1:0] src,
   input  logic              ex_valid,
   input  logic              ex_reg_write,
   input  logic [RA_W_P-1:0] ex_dst,
   input  logic              mem_reg_write,
   input  logic [RA_W_P-1:0] mem_dst,
   output fwd_sel_t          sel
);

   logic operand_live;
   logic hit_ex;
   logic hit_mem;

   assign operand_live = id_valid & use_reg & (src != ZERO_REG_P);
   assign hit_ex       = ex_valid & ex_reg_write & (ex_dst == src);
   assign hit_mem      = mem_reg_write & (mem_dst == src);

   always_comb begin
      sel = FWD_RF;
      if (!operand_live) begin
         sel = FWD_RF;
      end else if (hit_ex) begin
         sel = FWD_MEM;
      end else if (hit_mem) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID->EX forwarding select generator and load-use stall controller for the 5-stage pipeline.
// Tracks the destinations of the EX and MEM instructions and registers the operand-mux selects.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int              RA_W_P     = RA_W,
   parameter logic [RA_W-1:0] ZERO_REG_P = ZERO_REG
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [RA_W_P-1:0] id_rs,
   input  logic [RA_W_P-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [RA_W_P-1:0] id_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   output logic [1:0]        fwd_sel_a,
   output logic [1:0]        fwd_sel_b,
   output logic              stall,
   output logic              ex_valid
);

   ex_slot_t  ex_slot_reg;
   mem_slot_t mem_slot_reg;
   ex_slot_t  ex_slot_next;

   logic [1:0][RA_W_P-1:0] src;
   logic [1:0]             use_src;
   fwd_sel_t [1:0]         sel_next;
   fwd_sel_t [1:0]         sel_reg;

   logic ex_is_load;
   logic load_use;
   logic insert_bubble;

   assign src[0]     = id_rs;
   assign src[1]     = id_rt;
   assign use_src[0] = id_use_rs;
   assign use_src[1] = id_use_rt;

   // Operand A (index 0) and operand B (index 1) are resolved independently.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_operand
         fwd_sel_calc #(
            .RA_W_P     (RA_W_P),
            .ZERO_REG_P (ZERO_REG_P)
         ) u_sel (
            .id_valid      (id_valid),
            .use_reg       (use_src[gi]),
            .src           (src[gi]),
            .ex_valid      (ex_slot_reg.valid),
            .ex_reg_write  (ex_slot_reg.reg_write),
            .ex_dst        (ex_slot_reg.dst),
            .mem_reg_write (mem_slot_reg.reg_write),
            .mem_dst       (mem_slot_reg.dst),
            .sel           (sel_next[gi])
         );
      end
   endgenerate

   assign ex_is_load = ex_slot_reg.valid & ex_slot_reg.mem_read & (ex_slot_reg.dst != ZERO_REG_P);

   assign load_use = ex_is_load & id_valid &
                     ((id_use_rs & (id_rs == ex_slot_reg.dst)) |
                      (id_use_rt & (id_rt == ex_slot_reg.dst)));

   // A squashed instruction must not hold the front end, so flush masks the stall.
   assign stall         = load_use & ~flush;
   assign insert_bubble = flush | load_use;

   always_comb begin
      ex_slot_next           = EX_BUBBLE;
      ex_slot_next.dst       = id_dst;
      ex_slot_next.reg_write = id_reg_write & id_valid;
      ex_slot_next.mem_read  = id_mem_read & id_valid;
      ex_slot_next.valid     = id_valid;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_slot_reg  <= EX_BUBBLE;
         mem_slot_reg <= MEM_EMPTY;
         sel_reg      <= '0;
      end else begin
         mem_slot_reg <= ex_to_mem(ex_slot_reg);
         if (insert_bubble) begin
            ex_slot_reg <= EX_BUBBLE;
            sel_reg     <= '0;
         end else begin
            ex_slot_reg <= ex_slot_next;
            sel_reg     <= sel_next;
         end
      end
   end

   assign fwd_sel_a = sel_reg[0];
   assign fwd_sel_b = sel_reg[1];
   assign ex_valid  = ex_slot_reg.valid;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Table-driven bench with a select scoreboard for the forwarding / load-use hazard unit.
module tb_fwd_hazard_unit;
   import fwd_hazard_unit_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_use_rs;
   logic       id_use_rt;
   logic [4:0] id_dst;
   logic       id_reg_write;
   logic       id_mem_read;
   logic       flush;
   logic [1:0] fwd_sel_a;
   logic [1:0] fwd_sel_b;
   logic       stall;
   logic       ex_valid;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic       v;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic [4:0] dst;
      logic       rw;
      logic       mr;
      logic       fl;
      logic       st;
      logic [1:0] a;
      logic [1:0] b;
      logic       exv;
   } vec_t;

   typedef struct packed {
      logic [1:0] a;
      logic [1:0] b;
      logic       exv;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   fwd_hazard_unit dut (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .id_dst       (id_dst),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .flush        (flush),
      .fwd_sel_a    (fwd_sel_a),
      .fwd_sel_b    (fwd_sel_b),
      .stall        (stall),
      .ex_valid     (ex_valid)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input int v, input int rs, input int rt, input int urs,
                               input int urt, input int dst, input int rw, input int mr,
                               input int fl, input int st, input int a, input int b,
                               input int exv);
      vec_t r;
      r.v = 1'(v);  r.rs = 5'(rs);  r.rt = 5'(rt);  r.urs = 1'(urs);  r.urt = 1'(urt);
      r.dst = 5'(dst);  r.rw = 1'(rw);  r.mr = 1'(mr);  r.fl = 1'(fl);
      r.st = 1'(st);  r.a = 2'(a);  r.b = 2'(b);  r.exv = 1'(exv);
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic drive(input vec_t t);
      id_valid     = t.v;
      id_rs        = t.rs;
      id_rt        = t.rt;
      id_use_rs    = t.urs;
      id_use_rt    = t.urt;
      id_dst       = t.dst;
      id_reg_write = t.rw;
      id_mem_read  = t.mr;
      flush        = t.fl;
   endtask

   // One ID presentation: stall is checked combinationally, selects one edge later.
   task automatic step(input vec_t t, input string tag);
      exp_t e;
      @(negedge clk);
      drive(t);
      #1;
      chk({tag, " stall"}, int'(stall), int'(t.st));
      sb.push_back('{a: t.a, b: t.b, exv: t.exv});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, " scoreboard empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         chk({tag, " fwd_sel_a"}, int'(fwd_sel_a), int'(e.a));
         chk({tag, " fwd_sel_b"}, int'(fwd_sel_b), int'(e.b));
         chk({tag, " ex_valid"}, int'(ex_valid), int'(e.exv));
      end
      $display("txn %s: rs=%0d rt=%0d dst=%0d flush=%0d -> stall=%0d sel_a=%0d sel_b=%0d ex_valid=%0d",
               tag, t.rs, t.rt, t.dst, t.fl, t.st, fwd_sel_a, fwd_sel_b, ex_valid);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #12;
      chk("reset fwd_sel_a", int'(fwd_sel_a), 0);
      chk("reset fwd_sel_b", int'(fwd_sel_b), 0);
      chk("reset ex_valid", int'(ex_valid), 0);
      chk("reset stall", int'(stall), 0);
      @(negedge clk);
      reset = 1'b0;

      //             v rs rt urs urt dst rw mr fl | st a  b  exv
      tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 1)); // add $3,$1,$2
      tbl.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 2, 0, 1)); // sub $4,$3,$5
      tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 1)); // add $3,$1,$2
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // nop
      tbl.push_back(mk(1, 7, 3, 1, 1, 6, 1, 0, 0, 0, 0, 1, 1)); // or $6,$7,$3
      tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 1)); // add $3
      tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 1)); // add $3
      tbl.push_back(mk(1, 3, 3, 1, 1, 8, 1, 0, 0, 0, 2, 2, 1)); // and $8,$3,$3
      tbl.push_back(mk(1, 1, 5, 1, 0, 5, 1, 1, 0, 0, 0, 0, 1)); // lw $5,0($1)
      tbl.push_back(mk(1, 2, 5, 1, 1, 6, 1, 0, 0, 1, 0, 0, 0)); // add $6,$2,$5 stalls
      tbl.push_back(mk(1, 2, 5, 1, 1, 6, 1, 0, 0, 0, 0, 1, 1)); // add $6 replayed
      tbl.push_back(mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1)); // add $0,$1,$2
      tbl.push_back(mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 0, 0, 1)); // add $9,$0,$0
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1)); // lw $0,0($1)
      tbl.push_back(mk(1, 0, 0, 1, 1, 10, 1, 0, 0, 0, 0, 0, 1)); // add $10,$0,$0
      tbl.push_back(mk(1, 1, 5, 1, 0, 5, 1, 1, 0, 0, 0, 0, 1)); // lw $5,0($1)
      tbl.push_back(mk(1, 2, 5, 1, 0, 7, 1, 0, 0, 0, 0, 0, 1)); // rt=5 unused
      tbl.push_back(mk(1, 1, 5, 1, 0, 5, 1, 1, 0, 0, 0, 0, 1)); // lw $5,0($1)
      tbl.push_back(mk(1, 5, 2, 1, 1, 6, 1, 0, 1, 0, 0, 0, 0)); // add $6,$5,$2 flushed
      tbl.push_back(mk(1, 6, 2, 1, 1, 10, 1, 0, 0, 0, 0, 0, 1)); // or $10,$6,$2
      tbl.push_back(mk(1, 5, 6, 1, 1, 11, 1, 0, 0, 0, 0, 0, 1)); // and $11,$5,$6
      tbl.push_back(mk(0, 10, 11, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0)); // invalid ID
      tbl.push_back(mk(1, 11, 0, 1, 1, 12, 1, 0, 0, 0, 1, 0, 1)); // reads $11 from MEM

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i], $sformatf("vec%0d", i));
      end

      // Reset while EX holds a load, MEM holds a producer, and stall is high.
      step(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 1), "mid add $3");
      step(mk(1, 3, 5, 1, 0, 5, 1, 1, 0, 0, 2, 0, 1), "mid lw $5");
      @(negedge clk);
      drive(mk(1, 2, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0));
      #1;
      chk("mid pre-reset stall", int'(stall), 1);
      reset = 1'b1;
      #1;
      chk("mid reset fwd_sel_a", int'(fwd_sel_a), 0);
      chk("mid reset fwd_sel_b", int'(fwd_sel_b), 0);
      chk("mid reset ex_valid", int'(ex_valid), 0);
      chk("mid reset stall", int'(stall), 0);
      @(negedge clk);
      reset = 1'b0;
      step(mk(1, 5, 3, 1, 1, 7, 1, 0, 0, 0, 0, 0, 1), "post-reset add $7,$5,$3");

      if (sb.size() != 0) chk("scoreboard drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
